rfile_sb: RTL
=============

RFILE_SB -- requirements
Module: rfile_sb

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- XLEN, 32, register width.
- NREGS, 32, number of registers; power of two, at least 2.
- NREAD, 2, number of read ports.
- AW, $clog2(NREGS), address width; derived, not overridable.

REQ-002 The block SHALL have one clock and a synchronous active-high reset, with the following ports (name, direction, width, meaning):
- clk, in, 1, rising-edge clock.
- reset, in, 1, synchronous, active-high.
- rs_addr, in, NREAD*AW, read addresses; port i occupies slice i.
- read_en, in, NREAD, per-port read enable.
- rs_data, out, NREAD*XLEN, registered read data.
- rs_busy, out, NREAD, registered: the read register has a pending write.
- rd, in, AW, write address.
- rd_data, in, XLEN, write data.
- rd_write, in, 1, write enable.
- rsv_addr, in, AW, destination to reserve.
- rsv_valid, in, 1, reserve request.
- busy_vec, out, NREGS, current scoreboard state.

Function
REQ-003 Register 0 SHALL read as 0, ignore writes and never become busy.
REQ-004 A write SHALL occur at the rising edge when rd_write=1 and rd!=0.
REQ-005 Reads SHALL have 1-cycle latency: when read_en[i]=1 at an edge, rs_data slice i is updated at that edge with the contents of register rs_addr[i].
REQ-006 When read_en[i]=0, rs_data slice i and rs_busy[i] SHALL hold their previous values.
REQ-007 Write-through bypass: if rd_write=1, rd=rs_addr[i]!=0 and read_en[i]=1 in the same cycle, rs_data slice i SHALL capture rd_data, not the old contents.
REQ-008 Multiple read ports SHALL be allowed to address the same register in the same cycle; each port SHALL return identical data.
REQ-009 Scoreboard reserve: at the edge, busy[rsv_addr] SHALL be set when rsv_valid=1 and rsv_addr!=0.
REQ-010 Scoreboard release: at the edge, busy[rd] SHALL be cleared when rd_write=1.
REQ-011 Same-cycle reserve and release of the same address SHALL leave busy set (the new reservation wins); the data is still written.
REQ-012 Captured rs_busy[i] SHALL be busy[rs_addr[i]] with a same-cycle release applied (value = 0) and a same-cycle reserve not applied.
REQ-013 A write to a register that is not busy SHALL be legal; the data is written and busy stays 0.
REQ-014 busy_vec SHALL equal the busy register array directly; bit 0 is constant 0.
REQ-015 Address ranges SHALL be full, so no out-of-range check is needed.

Reset
REQ-016 While reset=1 at an edge, all registers, the busy array, rs_data and rs_busy SHALL become 0.
REQ-017 A write, read or reserve presented in the same cycle as reset=1 SHALL be ignored; reset SHALL have priority over all operations.
REQ-018 Reset asserted mid-operation SHALL discard all pending reservations; the first operation after reset deasserts SHALL see the all-zero state.

Structure
REQ-019 The block SHALL be a single module. Parameter defaults (XLEN=32, NREGS=32, NREAD=2) and the x0 address constant SHALL be placed in a shared package rfile_pkg for reuse by decode and hazard logic.
REQ-020 One sub-module, rfile_rdport, SHALL be instantiated NREAD times via generate; it implements REQ-005 to REQ-007 and REQ-012.
REQ-021 The storage SHALL be a register array, not an inferred RAM, so that the bypass and reset behaviour hold.

Verification
REQ-022 The bench SHALL cover the following directed scenarios (stimulus -> required response):
- Reset, then write reg1=-3 and reg2=3, then read port0=1 and port1=2 -> next cycle rs_data shows -3 and 3, rs_busy=00.
- Write reg0=0x55, then read reg0 on both ports -> rs_data reads 0 on both ports; busy_vec[0]=0.
- Write reg3=2 and read reg3 on port0 in the same cycle -> port0 shows 2 one cycle later (bypass).
- Reserve reg5, then read reg5 the next cycle -> rs_busy[0]=1 and busy_vec[5]=1; a later rd_write to reg5=7 with a same-cycle read -> rs_data=7, rs_busy[0]=0.
- Reserve reg4 and write reg4=9 in the same cycle -> busy_vec[4]=1 and reg4 reads 9; with read_en=0, outputs hold their previous values.
- Reserve regs 6 and 7, write reg6=1, then assert reset with rd_write=1 for reg8 -> busy_vec=0, reg6 and reg8 read 0, rs_data=0.

Source files
------------

// File: rtl/rfile_pkg.sv
// Shared constants for the register file / scoreboard and the decode and
// hazard logic that sits around it.
package rfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NREAD_DEF = 2;

  // Architectural zero register: reads 0, ignores writes, never busy.
  localparam int X0_ADDR = 0;

endpackage : rfile_pkg

// File: rtl/rfile_rdport.sv
// One registered read port: captures register data and busy state, with
// write-through bypass and same-cycle release applied to the captured value.
module rfile_rdport
  import rfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            read_en,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] reg_word,
  input  logic            reg_busy,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] rd_data,
  input  logic            rd_write,
  output logic [XLEN-1:0] data,
  output logic            busy
);

  logic write_hit;

  // A write to the register being read this cycle overrides the stored word
  // and releases its busy bit; x0 is never a hit because its writes are dropped.
  assign write_hit = rd_write && (rd == addr) && (addr != AW'(X0_ADDR));

  // Capture on read_en, otherwise hold; reset clears both outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      data <= '0;
      busy <= 1'b0;
    end else if (read_en) begin
      data <= write_hit ? rd_data : reg_word;
      // A same-cycle reserve is deliberately not visible here: reg_busy is the
      // current scoreboard state, not its next value.
      busy <= reg_busy && !write_hit;
    end
  end

endmodule : rfile_rdport

// File: rtl/rfile_sb.sv
// Multi-port register file with a per-register busy scoreboard. Reads are
// registered; writes release a reservation, reserves mark a pending write.
module rfile_sb
  import rfile_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NREAD = NREAD_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREAD*AW-1:0]   rs_addr,
  input  logic [NREAD-1:0]      read_en,
  output logic [NREAD*XLEN-1:0] rs_data,
  output logic [NREAD-1:0]      rs_busy,
  input  logic [AW-1:0]         rd,
  input  logic [XLEN-1:0]       rd_data,
  input  logic                  rd_write,
  input  logic [AW-1:0]         rsv_addr,
  input  logic                  rsv_valid,
  output logic [NREGS-1:0]      busy_vec
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_next;

  // Scoreboard next state: release first, then reserve, so a same-cycle
  // reserve of the released address wins.
  always_comb begin
    // NOTE: every always_comb output gets a full default before any
    // conditional update; a missing default path infers a latch.
    busy_next = busy_q;
    if (rd_write) begin
      busy_next[rd] = 1'b0;
    end
    if (rsv_valid) begin
      busy_next[rsv_addr] = 1'b1;
    end
    busy_next[X0_ADDR] = 1'b0;
  end

  // Register array and scoreboard state; reset takes priority over any
  // write or reserve presented in the same cycle.
  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: the storage is a flop array rather than a RAM, so it can (and
      // must) be cleared by reset; a RAM macro would have no reset.
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      if (rd_write && (rd != AW'(X0_ADDR))) begin
        regs[rd] <= rd_data;
      end
      busy_q <= busy_next;
    end
  end

  assign busy_vec = busy_q;

  for (genvar i = 0; i < NREAD; i++) begin : g_rdport
    logic [AW-1:0]   port_addr;
    logic [XLEN-1:0] port_word;
    logic            port_busy;

    assign port_addr = rs_addr[i*AW +: AW];
    assign port_word = regs[port_addr];
    assign port_busy = busy_q[port_addr];

    rfile_rdport #(
      .XLEN (XLEN),
      .AW   (AW)
    ) u_rdport (
      .clk      (clk),
      .reset    (reset),
      .read_en  (read_en[i]),
      .addr     (port_addr),
      .reg_word (port_word),
      .reg_busy (port_busy),
      .rd       (rd),
      .rd_data  (rd_data),
      .rd_write (rd_write),
      .data     (rs_data[i*XLEN +: XLEN]),
      .busy     (rs_busy[i])
    );
  end

endmodule : rfile_sb
